// File: rtl/data_mem_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package data_mem_pkg;

  localparam int unsigned MEM_DEPTH    = 32;
  localparam int unsigned MEM_LOCK_MAX = 8;
  localparam int unsigned AW           = 8;
  localparam int unsigned DW           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dm_resp_reg.sv
// Per-port response register: read data, read-valid pulse and range-error pulse.
module dm_resp_reg
  import data_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt,
  input  logic          we,
  input  logic          in_range,
  input  logic [DW-1:0] mem_rdata,
  output logic          rvalid,
  output logic          err,
  output logic [DW-1:0] rdata
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt & ~we;
      err    <= gnt & ~in_range;
      if (gnt && !we) rdata <= in_range ? mem_rdata : '0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with bounded lock sharing one data memory between two ports.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = MEM_DEPTH,
  parameter int unsigned LOCK_MAX = MEM_LOCK_MAX
) (
  input  logic          Oscillator,
  input  logic          Reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] ReadData
);

  localparam int unsigned CW       = $clog2(LOCK_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  arb_state_t    state, state_n;
  logic          last_gnt, last_n;
  logic [CW-1:0] lock_cnt, cnt_n;
  logic          in_range0, in_range1;
  logic          rv0, rv1, er0, er1;

  assign in_range0 = {1'b0, p0_addr} < DEPTH_W;
  assign in_range1 = {1'b0, p1_addr} < DEPTH_W;

  always_ff @(posedge Oscillator) begin
    if (Reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      last_gnt <= last_n;
      lock_cnt <= cnt_n;
    end
  end

  // The IDLE grant cycle is the first owned cycle, so release is checked on the
  // incremented count to cap ownership at LOCK_MAX cycles.
  always_comb begin
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    state_n = state;
    last_n  = last_gnt;
    cnt_n   = lock_cnt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (p0_req && (!p1_req || last_gnt)) p0_gnt = 1'b1;
        else if (p1_req)                    p1_gnt = 1'b1;
        if (p0_gnt) begin
          last_n = 1'b0;
          if (p0_lock) state_n = OWN0;
        end
        if (p1_gnt) begin
          last_n = 1'b1;
          if (p1_lock) state_n = OWN1;
        end
      end
      OWN0: begin
        p0_gnt = p0_req;
        cnt_n  = lock_cnt + CW'(1);
        if (p0_gnt) last_n = 1'b0;
        if (!p0_lock || cnt_n == CNT_LAST) begin
          state_n = IDLE;
          last_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      OWN1: begin
        p1_gnt = p1_req;
        cnt_n  = lock_cnt + CW'(1);
        if (p1_gnt) last_n = 1'b1;
        if (!p1_lock || cnt_n == CNT_LAST) begin
          state_n = IDLE;
          last_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (Reset) begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end
  end

  always_comb begin
    Address   = '0;
    WriteData = '0;
    if (p0_gnt) begin
      Address   = p0_addr;
      WriteData = p0_wdata;
    end else if (p1_gnt) begin
      Address   = p1_addr;
      WriteData = p1_wdata;
    end
  end

  assign MemWrite = (p0_gnt & p0_we & in_range0) | (p1_gnt & p1_we & in_range1);
  assign MemRead  = (p0_gnt & ~p0_we & in_range0) | (p1_gnt & ~p1_we & in_range1);

  dm_resp_reg u_resp0 (
    .clk       (Oscillator),
    .rst       (Reset),
    .gnt       (p0_gnt),
    .we        (p0_we),
    .in_range  (in_range0),
    .mem_rdata (ReadData),
    .rvalid    (rv0),
    .err       (er0),
    .rdata     (p0_rdata)
  );

  dm_resp_reg u_resp1 (
    .clk       (Oscillator),
    .rst       (Reset),
    .gnt       (p1_gnt),
    .we        (p1_we),
    .in_range  (in_range1),
    .mem_rdata (ReadData),
    .rvalid    (rv1),
    .err       (er1),
    .rdata     (p1_rdata)
  );

  // Pulses registered just before Reset must not leak out during the Reset cycle.
  assign p0_rvalid = rv0 & ~Reset;
  assign p0_err    = er0 & ~Reset;
  assign p1_rvalid = rv1 & ~Reset;
  assign p1_err    = er1 & ~Reset;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 32x8 memory attached.
module tb_data_mem_arbiter;

  logic       Oscillator = 1'b0;
  logic       Reset;
  logic       p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [7:0] p0_rdata, p1_rdata;
  logic [7:0] Address, WriteData, ReadData;
  logic       MemWrite, MemRead;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:31];

  always #5 Oscillator = ~Oscillator;

  always @(posedge Oscillator) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 17) ? 8'hFF : 8'(i);
    end else if (MemWrite) begin
      mem[Address[4:0]] <= WriteData;
    end
  end
  assign ReadData = (Address < 8'd32) ? mem[Address[4:0]] : 8'h00;

  data_mem_arbiter #(.DEPTH(32), .LOCK_MAX(8)) dut (
    .Oscillator (Oscillator), .Reset (Reset),
    .p0_req (p0_req), .p0_we (p0_we), .p0_lock (p0_lock), .p0_addr (p0_addr),
    .p0_wdata (p0_wdata), .p0_gnt (p0_gnt), .p0_rvalid (p0_rvalid),
    .p0_rdata (p0_rdata), .p0_err (p0_err),
    .p1_req (p1_req), .p1_we (p1_we), .p1_lock (p1_lock), .p1_addr (p1_addr),
    .p1_wdata (p1_wdata), .p1_gnt (p1_gnt), .p1_rvalid (p1_rvalid),
    .p1_rdata (p1_rdata), .p1_err (p1_err),
    .Address (Address), .WriteData (WriteData), .MemWrite (MemWrite),
    .MemRead (MemRead), .ReadData (ReadData)
  );

  typedef struct {
    logic       r0, w0, l0;
    logic [7:0] a0, d0;
    logic       r1, w1, l1;
    logic [7:0] a1, d1;
    logic       eg0, eg1, emw, emr;
    logic [7:0] ea, ewd;
    logic       ev0;
    logic [7:0] ed0;
    logic       ee0, ev1;
    logic [7:0] ed1;
    logic       ee1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, w0, l0, input logic [7:0] a0, d0,
                       input logic r1, w1, l1, input logic [7:0] a1, d1);
    p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge Oscillator);
    #1;
  endtask

  initial begin
    //        r0 w0 l0 a0     d0     r1 w1 l1 a1     d1     g0 g1 mw mr ea     ewd    v0 d0     e0 v1 d1     e1
    vecs[0]  = '{1,0,0,8'd5, 8'h00, 0,0,0,8'd0, 8'h00, 1,0,0,1,8'd5, 8'h00, 0,8'h00,0,0,8'h00,0};
    vecs[1]  = '{0,0,0,8'd0, 8'h00, 0,0,0,8'd0, 8'h00, 0,0,0,0,8'd0, 8'h00, 1,8'h05,0,0,8'h00,0};
    vecs[2]  = '{1,0,0,8'd17,8'h00, 1,0,0,8'd3, 8'h00, 0,1,0,1,8'd3, 8'h00, 0,8'h05,0,0,8'h00,0};
    vecs[3]  = '{1,0,0,8'd17,8'h00, 1,0,0,8'd3, 8'h00, 1,0,0,1,8'd17,8'h00, 0,8'h05,0,1,8'h03,0};
    vecs[4]  = '{1,0,0,8'd17,8'h00, 1,0,0,8'd3, 8'h00, 0,1,0,1,8'd3, 8'h00, 1,8'hFF,0,0,8'h03,0};
    vecs[5]  = '{1,0,0,8'd17,8'h00, 1,0,0,8'd3, 8'h00, 1,0,0,1,8'd17,8'h00, 0,8'hFF,0,1,8'h03,0};
    vecs[6]  = '{0,0,0,8'd0, 8'h00, 1,1,0,8'd9, 8'hA5, 0,1,1,0,8'd9, 8'hA5, 1,8'hFF,0,0,8'h03,0};
    vecs[7]  = '{1,0,0,8'd9, 8'h00, 0,0,0,8'd0, 8'h00, 1,0,0,1,8'd9, 8'h00, 0,8'hFF,0,0,8'h03,0};
    vecs[8]  = '{1,0,0,8'd40,8'h00, 0,0,0,8'd0, 8'h00, 1,0,0,0,8'd40,8'h00, 1,8'hA5,0,0,8'h03,0};
    vecs[9]  = '{1,1,0,8'd32,8'h77, 0,0,0,8'd0, 8'h00, 1,0,0,0,8'd32,8'h77, 1,8'h00,1,0,8'h03,0};
    vecs[10] = '{0,0,0,8'd0, 8'h00, 0,0,0,8'd0, 8'h00, 0,0,0,0,8'd0, 8'h00, 0,8'h00,1,0,8'h03,0};
    vecs[11] = '{0,0,0,8'd0, 8'h00, 1,0,0,8'd255,8'h00,0,1,0,0,8'd255,8'h00,0,8'h00,0,0,8'h03,0};
    vecs[12] = '{0,0,0,8'd0, 8'h00, 0,0,0,8'd0, 8'h00, 0,0,0,0,8'd0, 8'h00, 0,8'h00,0,1,8'h00,1};

    Reset = 1'b1;
    drive(0,0,0,8'd0,8'd0, 0,0,0,8'd0,8'd0);
    repeat (2) @(posedge Oscillator);
    #1;
    @(negedge Oscillator);
    chk("reset_gnt", {p0_gnt, p1_gnt}, 2'b00);
    chk("reset_mem", {MemWrite, MemRead}, 2'b00);
    next_cycle();
    Reset = 1'b0;
    @(negedge Oscillator);
    chk("reset_resp", {p0_rvalid, p0_err, p1_rvalid, p1_err}, 4'b0000);
    chk("reset_rdata", {p0_rdata, p1_rdata}, 16'h0000);
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1);
      @(negedge Oscillator);
      chk($sformatf("v%0d_gnt", i), {p0_gnt, p1_gnt}, {vecs[i].eg0, vecs[i].eg1});
      chk($sformatf("v%0d_memctl", i), {MemWrite, MemRead}, {vecs[i].emw, vecs[i].emr});
      chk($sformatf("v%0d_addr", i), {Address, WriteData}, {vecs[i].ea, vecs[i].ewd});
      chk($sformatf("v%0d_resp0", i), {p0_rvalid, p0_err, p0_rdata},
          {vecs[i].ev0, vecs[i].ee0, vecs[i].ed0});
      chk($sformatf("v%0d_resp1", i), {p1_rvalid, p1_err, p1_rdata},
          {vecs[i].ev1, vecs[i].ee1, vecs[i].ed1});
      next_cycle();
    end

    // Lock: last grant went to p1, so p0 wins, owns 8 cycles, then p1 gets one.
    drive(1,0,1,8'd1,8'd0, 1,0,0,8'd2,8'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge Oscillator);
      chk($sformatf("lock_c%0d", c), {p0_gnt, p1_gnt},
          ((c % 9) == 8) ? 2'b01 : 2'b10);
      next_cycle();
    end
    // Voluntary release while owning, then plain alternation.
    p0_lock = 1'b0;
    @(negedge Oscillator);
    chk("unlock_c20", {p0_gnt, p1_gnt}, 2'b10);
    next_cycle();
    @(negedge Oscillator);
    chk("unlock_c21", {p0_gnt, p1_gnt}, 2'b01);
    next_cycle();
    @(negedge Oscillator);
    chk("unlock_c22", {p0_gnt, p1_gnt}, 2'b10);
    next_cycle();

    // Reset right after a p1 read grant.
    drive(0,0,0,8'd0,8'd0, 1,0,0,8'd4,8'd0);
    @(negedge Oscillator);
    chk("rst_pre_gnt", {p0_gnt, p1_gnt}, 2'b01);
    next_cycle();
    Reset = 1'b1;
    drive(1,0,0,8'd5,8'd0, 0,0,0,8'd0,8'd0);
    @(negedge Oscillator);
    chk("rst_cyc_rvalid", p1_rvalid, 1'b0);
    chk("rst_cyc_gnt", {p0_gnt, p1_gnt, MemRead, MemWrite}, 4'b0000);
    next_cycle();
    Reset = 1'b0;
    drive(1,0,0,8'd5,8'd0, 1,0,0,8'd6,8'd0);
    @(negedge Oscillator);
    chk("rst_post_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
    chk("rst_post_tie", {p0_gnt, p1_gnt}, 2'b10);
    next_cycle();
    @(negedge Oscillator);
    chk("rst_post_alt", {p0_gnt, p1_gnt}, 2'b01);
    chk("rst_post_rd0", {p0_rvalid, p0_rdata}, {1'b1, 8'h05});
    next_cycle();
    drive(0,0,0,8'd0,8'd0, 0,0,0,8'd0,8'd0);
    @(negedge Oscillator);
    chk("rst_post_rd1", {p1_rvalid, p1_rdata}, {1'b1, 8'h06});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
